gpio_port: RTL and testbench

Parametrised GPIO port peripheral, the successor to the fixed GPIOA/B/C blocks at GPIOA_BASE_ADDR/GPIOB_BASE_ADDR/GPIOC_BASE_ADDR.

- Provides per-pin direction, output latch and synchronised input.
- Adds per-pin edge-interrupt modes, W1C pending bits, and routing of each pin to one of two interrupt lines. The lines map to TRAP_CODE_GPIOx0 / TRAP_CODE_GPIOx1.
- Sits on the core's memory-mapped peripheral bus and decodes a 16-byte window (GPIO_ADDR_WIDTH = 4).

---
 rtl/gpio_port.sv | 133 +++++++++++++
 tb/tb_gpio_port.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
// GPIO port: per-pin direction, output latch, synchronised input, edge
// interrupts with W1C pending bits routed onto two interrupt lines.

module gpio_pin #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       sync_in,
  output logic       pend
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;
  logic                   rise, fall, hit;

  assign sync_in = chain[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev;
  assign fall    = ~sync_in & prev;
  assign hit     = (mode[0] & rise) | (mode[1] & fall);

  // A new event outranks a W1C landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
      pend  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      prev  <= sync_in;
      pend  <= (pend & ~clr) | hit;
    end
  end
endmodule

module gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [3:0]       addr,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strobe,
  output logic [31:0]      rd_data,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq0,
  output logic             irq1
);
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [31:0] mask;
  } bus_req_t;

  bus_req_t           req;
  logic [WIDTH-1:0]   dir, odata, route, pend, sync_in, clr;
  logic [2*WIDTH-1:0] imode;
  logic [31:0]        rd_mux;
  logic               unused_bus;

  always_comb begin
    req.rd   = rd_en;
    req.wr   = wr_en;
    req.sel  = addr[3:2];
    req.data = wr_data;
    req.mask = {{8{wr_strobe[3]}}, {8{wr_strobe[2]}}, {8{wr_strobe[1]}}, {8{wr_strobe[0]}}};
  end

  assign unused_bus = ^{addr[1:0], req.data, req.mask};

  assign clr = (req.wr && req.sel == 2'd3) ? (req.data[WIDTH-1:0] & req.mask[WIDTH-1:0]) : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
      .clk    (clk),
      .rst    (rst),
      .pin    (gpio_in[i]),
      .mode   (imode[2*i +: 2]),
      .clr    (clr[i]),
      .sync_in(sync_in[i]),
      .pend   (pend[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir   <= '0;
      odata <= '0;
      imode <= '0;
      route <= '0;
    end else if (req.wr) begin
      case (req.sel)
        2'd0: dir   <= (dir & ~req.mask[WIDTH-1:0]) | (req.data[WIDTH-1:0] & req.mask[WIDTH-1:0]);
        2'd1: odata <= (odata & ~req.mask[WIDTH-1:0]) | (req.data[WIDTH-1:0] & req.mask[WIDTH-1:0]);
        2'd2: imode <= (imode & ~req.mask[2*WIDTH-1:0]) | (req.data[2*WIDTH-1:0] & req.mask[2*WIDTH-1:0]);
        default: route <= (route & ~req.mask[16 +: WIDTH]) | (req.data[16 +: WIDTH] & req.mask[16 +: WIDTH]);
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (req.sel)
      2'd0: rd_mux[WIDTH-1:0]   = dir;
      2'd1: rd_mux[WIDTH-1:0]   = (dir & odata) | (~dir & sync_in);
      2'd2: rd_mux[2*WIDTH-1:0] = imode;
      default: begin
        rd_mux[WIDTH-1:0]  = pend;
        rd_mux[16 +: WIDTH] = route;
      end
    endcase
  end

  // Read samples pre-write state, so a same-cycle write is not visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rd_data <= '0;
    else if (req.rd) rd_data <= rd_mux;
  end

  assign gpio_out = odata;
  assign gpio_oe  = dir;
  assign irq0     = |(pend & ~route);
  assign irq1     = |(pend & route);
endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: three instances (8/2, 16/3, 1/2) on a shared bus,
// reads scored through an expectation queue drained by a monitor.

module tb_gpio_port;
  logic        clk = 1'b0, rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [3:0]  addr = '0, wr_strobe = '0;
  logic [31:0] wr_data = '0;

  logic [7:0]  in_a = '0, out_a, oe_a;
  logic [15:0] in_w = '0, out_w, oe_w;
  logic [0:0]  in_n = '0, out_n, oe_n;
  logic [31:0] rd_a, rd_w, rd_n;
  logic        irq0_a, irq1_a, irq0_w, irq1_w, irq0_n, irq1_n;

  int n_vec = 0, n_err = 0;

  typedef struct {
    string       nm;
    logic [2:0]  chk;
    logic [31:0] e0, e1, e2;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  gpio_port #(.WIDTH(8), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
    .wr_strobe(wr_strobe), .rd_data(rd_a), .gpio_in(in_a), .gpio_out(out_a), .gpio_oe(oe_a),
    .irq0(irq0_a), .irq1(irq1_a));

  gpio_port #(.WIDTH(16), .SYNC_STAGES(3)) u_w (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
    .wr_strobe(wr_strobe), .rd_data(rd_w), .gpio_in(in_w), .gpio_out(out_w), .gpio_oe(oe_w),
    .irq0(irq0_w), .irq1(irq1_w));

  gpio_port #(.WIDTH(1), .SYNC_STAGES(2)) u_n (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
    .wr_strobe(wr_strobe), .rd_data(rd_n), .gpio_in(in_n), .gpio_out(out_n), .gpio_oe(oe_n),
    .irq0(irq0_n), .irq1(irq1_n));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    wr_en = 1'b1; addr = a; wr_data = d; wr_strobe = s;
    @(negedge clk);
    wr_en = 1'b0; wr_strobe = '0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [2:0] c, input logic [31:0] e0,
                    input logic [31:0] e1, input logic [31:0] e2, input string nm);
    exp_t x;
    @(negedge clk);
    rd_en = 1'b1; addr = a;
    x.nm = nm; x.chk = c; x.e0 = e0; x.e1 = e1; x.e2 = e2;
    sbq.push_back(x);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic rd_a1(input logic [3:0] a, input logic [31:0] e, input string nm);
    rd(a, 3'b001, e, '0, '0, nm);
  endtask

  // Monitor: rd_data is valid the cycle after a sampled rd_en.
  initial forever begin
    @(posedge clk);
    if (rd_en) begin : pop
      exp_t x;
      @(negedge clk);
      if (sbq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_read: got %h, expected no read", rd_a);
      end else begin
        x = sbq.pop_front();
        if (x.chk[0]) chk({x.nm, "_w8"},  rd_a, x.e0);
        if (x.chk[1]) chk({x.nm, "_w16"}, rd_w, x.e1);
        if (x.chk[2]) chk({x.nm, "_w1"},  rd_n, x.e2);
      end
    end
  end

  initial begin
    // Reset, then async re-assertion mid-cycle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr(4'h0, 32'hFF, 4'hF);
    wr(4'h4, 32'h5A, 4'hF);
    chk("pre_reset_out", out_a, 32'h5A);
    in_a = 8'h3C;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_oe", oe_a, 0);
    chk("rst_out", out_a, 0);
    chk("rst_irq", {irq0_a, irq1_a}, 0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    rd_a1(4'h0, 32'h0, "rst_dir");
    rd_a1(4'h4, 32'h3C, "rst_data");
    rd_a1(4'h8, 32'h0, "rst_imode");
    rd_a1(4'hC, 32'h0, "rst_ipend");

    // Output path and strobes
    wr(4'h0, 32'hF0, 4'hF);
    wr(4'h4, 32'hA5, 4'hF);
    chk("oe", oe_a, 32'hF0);
    chk("out", out_a, 32'hA5);
    in_a = 8'h0C;
    repeat (3) @(negedge clk);
    rd_a1(4'h4, 32'hAC, "data_mix");
    wr(4'h4, 32'hFF, 4'h0);
    chk("strobe0_out", out_a, 32'hA5);
    wr(4'h0, 32'h0F, 4'hE);
    chk("strobe_hi_oe", oe_a, 32'hF0);

    // Rising edge on pin3 to irq0
    in_a = 8'h00;
    repeat (4) @(negedge clk);
    wr(4'h8, 32'h40, 4'hF);
    @(negedge clk); in_a = 8'h08;
    repeat (2) @(negedge clk);
    chk("rise_early", irq0_a, 0);
    @(negedge clk);
    chk("rise_irq0", irq0_a, 1);
    chk("rise_irq1", irq1_a, 0);
    rd_a1(4'hC, 32'h08, "rise_pend");
    in_a = 8'h00;
    repeat (5) @(negedge clk);
    rd_a1(4'hC, 32'h08, "fall_no_set");
    wr(4'hC, 32'h08, 4'h1);
    chk("w1c_irq0", irq0_a, 0);
    rd_a1(4'hC, 32'h0, "w1c_pend");

    // Both edges on pin5 routed to irq1
    wr(4'h8, 32'h0C40, 4'h3);
    wr(4'hC, 32'h0020_0000, 4'h4);
    in_a = 8'h20;
    repeat (4) @(negedge clk);
    chk("both_irq1", irq1_a, 1);
    chk("both_irq0", irq0_a, 0);
    in_a = 8'h00;
    repeat (4) @(negedge clk);
    rd_a1(4'hC, 32'h0020_0020, "both_pend");
    wr(4'hC, 32'h20, 4'h1);
    chk("w1c_irq1", irq1_a, 0);
    chk("w1c_irq1_irq0", irq0_a, 0);
    rd_a1(4'hC, 32'h0020_0000, "route_keep");

    // Set/clear collision on pin3
    @(negedge clk); in_a = 8'h08;
    repeat (2) @(negedge clk);
    wr_en = 1'b1; addr = 4'hC; wr_data = 32'h08; wr_strobe = 4'h1;
    @(negedge clk);
    wr_en = 1'b0; wr_strobe = '0;
    chk("collide_irq0", irq0_a, 1);
    rd_a1(4'hC, 32'h0020_0008, "collide_pend");
    wr(4'hC, 32'h08, 4'h1);
    rd_a1(4'hC, 32'h0020_0000, "collide_clr");

    // Same-cycle read and write returns the old value
    @(negedge clk);
    rd_en = 1'b1; wr_en = 1'b1; addr = 4'h0; wr_data = 32'h33; wr_strobe = 4'hF;
    sbq.push_back('{nm: "rw_old", chk: 3'b001, e0: 32'hF0, e1: 32'h0, e2: 32'h0});
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0; wr_strobe = '0;
    rd_a1(4'h0, 32'h33, "rw_new");

    // Width sweep: unused bits read 0
    wr(4'h0, 32'hFFFF_FFFF, 4'hF);
    wr(4'h4, 32'hFFFF_FFFF, 4'hF);
    rd(4'h0, 3'b111, 32'hFF, 32'hFFFF, 32'h1, "sw_dir");
    rd(4'h4, 3'b111, 32'hFF, 32'hFFFF, 32'h1, "sw_data");
    wr(4'h8, 32'hFFFF_FFFF, 4'hF);
    rd(4'h8, 3'b111, 32'hFFFF, 32'hFFFF_FFFF, 32'h3, "sw_imode");
    wr(4'hC, 32'hFFFF_FFFF, 4'hF);
    rd(4'hC, 3'b111, 32'h00FF_0000, 32'hFFFF_0000, 32'h0001_0000, "sw_route");
    wr(4'hC, 32'h0000_FFFF, 4'hF);

    // Latency: 3 edges at SYNC_STAGES=2, 4 edges at SYNC_STAGES=3
    @(negedge clk); in_w = 16'h8000; in_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("lat_w16_e2", irq0_w, 0);
    chk("lat_w1_e2", irq0_n, 0);
    @(negedge clk);
    chk("lat_w1_e3", irq0_n, 1);
    chk("lat_w16_e3", irq0_w, 0);
    @(negedge clk);
    chk("lat_w16_e4", irq0_w, 1);
    chk("lat_w16_irq1", irq1_w, 0);
    rd(4'hC, 3'b111, 32'h0, 32'h8000, 32'h1, "sw_pend");

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d pending reads, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
